ifetch_unit: RTL

Instruction fetch unit that produces the `inst`/`addr` pair consumed by the RV32I decoder. It owns the program counter, issues word requests to instruction memory over a request/grant/response handshake, and buffers returned words in a small FIFO. A valid/ready handshake toward the decode stage lets decode stall fetch, and a redirect port lets branch/jump resolution restart fetch at a new PC.

---
 rtl/ifetch_unit_pkg.sv | 24 ++
 rtl/ifu_fifo.sv | 54 +++++
 rtl/ifetch_unit.sv | 132 +++++++++++++
 3 files changed

// File: rtl/ifetch_unit_pkg.sv
// Shared fetch/decode definitions: FSM states, NOP word and common constants.
// The FAULT state exists only when IFU_MISALIGN_CHECK_EN is defined.
package ifetch_unit_pkg;

    localparam logic [31:0] NOP              = 32'h0000_0013;
    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;
    localparam int unsigned FIFO_W           = 64;

    localparam logic       WriteEnable = 1'b1;
    localparam logic [4:0] ZeroReg     = 5'd0;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_REQ   = 3'd1,
        S_WAIT  = 3'd2,
        S_DRAIN = 3'd3,
        S_HOLD  = 3'd4
`ifdef IFU_MISALIGN_CHECK_EN
        ,
        S_FAULT = 3'd5
`endif
    } ifu_state_e;

endpackage

// File: rtl/ifu_fifo.sv
// Instruction buffer holding {pc, inst} pairs between fetch and decode.
// Flush wins over push/pop; push into a full buffer is legal alongside a pop.
module ifu_fifo
    import ifetch_unit_pkg::*;
#(
    parameter int DEPTH = 2,
    localparam int PW = $clog2(DEPTH),
    localparam int CW = $clog2(DEPTH + 1)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              push,
    input  logic              pop,
    input  logic [FIFO_W-1:0] wdata,
    output logic [FIFO_W-1:0] rdata,
    output logic [CW-1:0]     count,
    output logic              full,
    output logic              empty
);

    logic [FIFO_W-1:0] mem [DEPTH];
    logic [PW-1:0]     wr_ptr;
    logic [PW-1:0]     rd_ptr;
    logic              do_push;
    logic              do_pop;

    assign empty   = (count == '0);
    assign full    = (count == CW'(DEPTH));
    assign do_pop  = pop && !empty && !flush;
    assign do_push = push && (!full || do_pop) && !flush;
    assign rdata   = mem[rd_ptr];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + PW'(1);
            count <= count + CW'(do_push) - CW'(do_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= wdata;
    end

endmodule

// File: rtl/ifetch_unit.sv
// Instruction fetch: PC, single-outstanding imem request FSM and decode buffer.
// Defining IFU_MISALIGN_CHECK_EN adds fetch_misaligned_o and the FAULT state.
module ifetch_unit
    import ifetch_unit_pkg::*;
#(
    parameter logic [31:0] RESET_PC   = RESET_PC_DEFAULT,
    parameter int          FIFO_DEPTH = 2
) (
    input  logic        clk_i,
    input  logic        rst_i,
    output logic        imem_req_o,
    output logic [31:0] imem_addr_o,
    input  logic        imem_gnt_i,
    input  logic        imem_rvalid_i,
    input  logic [31:0] imem_rdata_i,
    input  logic        redirect_i,
    input  logic [31:0] redirect_pc_i,
    output logic        inst_valid_o,
    input  logic        inst_ready_i,
    output logic [31:0] inst_o,
`ifdef IFU_MISALIGN_CHECK_EN
    output logic        fetch_misaligned_o,
`endif
    output logic [31:0] addr_o
);

    localparam int CW = $clog2(FIFO_DEPTH + 1);

    ifu_state_e        state;
    ifu_state_e        nxt;
    ifu_state_e        drain_exit;
    ifu_state_e        redirect_exit;
    logic [31:0]       pc;
    logic [31:0]       pc_req;
    logic [31:0]       target;
    logic              push;
    logic              pop;
    logic              pending;
    logic              empty;
    logic              full;
    logic [CW-1:0]     count;
    logic [CW-1:0]     cnt_after;
    logic [FIFO_W-1:0] rdata;

`ifdef IFU_MISALIGN_CHECK_EN
    logic fault;
    logic bad_target;

    assign bad_target         = (redirect_pc_i[1:0] != 2'b00);
    assign target             = redirect_pc_i;
    assign drain_exit         = fault ? S_FAULT : S_REQ;
    assign redirect_exit      = bad_target ? S_FAULT : S_REQ;
    assign fetch_misaligned_o = fault;
`else
    assign target        = redirect_pc_i & 32'hFFFF_FFFC;
    assign drain_exit    = S_REQ;
    assign redirect_exit = S_REQ;
`endif

    assign imem_addr_o  = pc;
    assign inst_valid_o = !empty;
    assign inst_o       = empty ? NOP : rdata[31:0];
    assign addr_o       = empty ? '0 : rdata[63:32];

    // A response is still owed to us after this cycle
    assign pending = ((state == S_WAIT || state == S_DRAIN) && !imem_rvalid_i)
                   || (state == S_REQ && imem_gnt_i);

    assign pop       = inst_valid_o && inst_ready_i && !redirect_i;
    assign push      = (state == S_WAIT) && imem_rvalid_i && !redirect_i;
    assign cnt_after = count + CW'(1) - CW'(pop);

    always_comb begin
        nxt = state;
        if (redirect_i) begin
            nxt = pending ? S_DRAIN : redirect_exit;
        end else begin
            unique case (state)
                S_IDLE:  nxt = S_REQ;
                S_REQ:   if (imem_gnt_i) nxt = S_WAIT;
                S_WAIT:  if (imem_rvalid_i)
                             nxt = (cnt_after < CW'(FIFO_DEPTH)) ? S_REQ : S_HOLD;
                S_HOLD:  if (!full) nxt = S_REQ;
                S_DRAIN: if (imem_rvalid_i) nxt = drain_exit;
`ifdef IFU_MISALIGN_CHECK_EN
                S_FAULT: nxt = S_FAULT;
`endif
                default: nxt = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state      <= S_IDLE;
            pc         <= RESET_PC;
            pc_req     <= '0;
            imem_req_o <= 1'b0;
`ifdef IFU_MISALIGN_CHECK_EN
            fault      <= 1'b0;
`endif
        end else begin
            state      <= nxt;
            imem_req_o <= (nxt == S_REQ);
            if (redirect_i) begin
                pc <= target;
            end else if (state == S_REQ && imem_gnt_i) begin
                pc     <= pc + 32'd4;
                pc_req <= pc;
            end
`ifdef IFU_MISALIGN_CHECK_EN
            if (redirect_i) fault <= bad_target;
`endif
        end
    end

    ifu_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk_i),
        .rst   (rst_i),
        .flush (redirect_i),
        .push  (push),
        .pop   (pop),
        .wdata ({pc_req, imem_rdata_i}),
        .rdata (rdata),
        .count (count),
        .full  (full),
        .empty (empty)
    );

endmodule
